// File: rtl/imem_loader.sv
// Boot-time instruction memory loader: assembles a big-endian byte stream
// into 32-bit words, writes them sequentially, then verifies an XOR checksum.
//
// Ports:
//   clock, reset          rising-edge clock, async active-high reset
//   start                 pulse; begins a load from IDLE, DONE or ERROR
//   byte_in, byte_valid   incoming stream byte and its valid flag
//   byte_ready            high in LOAD and CHECK (state-only)
//   wr_en, wr_addr,       registered one-cycle write strobe per word,
//   wr_data               word index and assembled word
//   core_reset            low only once the image is loaded and verified
//   done, error           checksum matched / mismatched
module imem_loader #(
    parameter int ADDR_W = 3,
    parameter int WORDS  = 8
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic [7:0]        byte_in,
    input  logic              byte_valid,
    output logic              byte_ready,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [31:0]       wr_data,
    output logic              core_reset,
    output logic              done,
    output logic              error
);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        CHECK,
        DONE,
        ERROR
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_WORD = ADDR_W'(WORDS - 1);

    state_t            state;
    state_t            next_state;
    logic [1:0]        byte_cnt;
    logic [ADDR_W-1:0] word_cnt;
    logic [23:0]       asm_reg;
    logic [7:0]        csum;
    logic              accept;
    logic              start_load;
    logic              last_byte;

    assign byte_ready = (state == LOAD) || (state == CHECK);
    assign accept     = byte_valid && byte_ready;
    assign start_load = start &&
                        ((state == IDLE) || (state == DONE) || (state == ERROR));
    assign last_byte  = (byte_cnt == 2'd3) && (word_cnt == LAST_WORD);

    assign core_reset = (state != DONE);
    assign done       = (state == DONE);
    assign error      = (state == ERROR);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        unique case (state)
            IDLE, DONE, ERROR: begin
                if (start) next_state = LOAD;
            end
            LOAD: begin
                if (accept && last_byte) next_state = CHECK;
            end
            CHECK: begin
                if (accept) next_state = (byte_in == csum) ? DONE : ERROR;
            end
            default: next_state = IDLE;
        endcase
    end

    // Word counter advances with the 4th byte; the write presents the
    // pre-increment index, so externally the address matches the word index.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            byte_cnt <= '0;
            word_cnt <= '0;
            asm_reg  <= '0;
            csum     <= '0;
            wr_en    <= 1'b0;
            wr_addr  <= '0;
            wr_data  <= '0;
        end else begin
            wr_en <= 1'b0;
            if (start_load) begin
                byte_cnt <= '0;
                word_cnt <= '0;
                asm_reg  <= '0;
                csum     <= '0;
            end else if (state == LOAD && accept) begin
                csum     <= csum ^ byte_in;
                byte_cnt <= byte_cnt + 2'd1;
                if (byte_cnt == 2'd3) begin
                    wr_en    <= 1'b1;
                    wr_addr  <= word_cnt;
                    wr_data  <= {asm_reg, byte_in};
                    word_cnt <= word_cnt + ADDR_W'(1);
                end else begin
                    asm_reg <= {asm_reg[15:0], byte_in};
                end
            end
        end
    end

endmodule
